// File: rtl/axi_tri_cmd_queue_if.sv
// Bus bundle for the triangle command queue: AXI4-Lite write channels,
// the descriptor stream towards the rasterizer and the FIFO status flags.
interface axi_tri_cmd_queue_if #(
    parameter int NUM_WORDS = 6,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 14
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]      axi_awaddr;
    logic                   axi_awvalid;
    logic                   axi_awready;
    logic [31:0]            axi_wdata;
    logic                   axi_wvalid;
    logic                   axi_wready;
    logic [1:0]             axi_bresp;
    logic                   axi_bvalid;
    logic                   axi_bready;
    logic [NUM_WORDS*32-1:0] tri_data;
    logic                   tri_valid;
    logic                   tri_ready;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready, tri_ready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               tri_data, tri_valid, fifo_count, fifo_empty, fifo_full
    );

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wvalid, axi_bready, tri_ready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               tri_data, tri_valid, fifo_count, fifo_empty, fifo_full
    );
endinterface

// File: rtl/axi_tri_cmd_queue.sv
// Write-only AXI4-Lite slave that stages NUM_WORDS descriptor words and
// commits them into a DEPTH-entry first-word-fall-through FIFO.
// Word i lives at byte 4*i; CTRL (bit0 commit, bit1 flush) follows the words.
module axi_tri_cmd_queue #(
    parameter int NUM_WORDS   = 6,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 14,
    parameter int AUTO_COMMIT = 1
) (
    input logic                axi_aclk,
    input logic                axi_aresetn,
    axi_tri_cmd_queue_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int DATA_W = NUM_WORDS * 32;
    localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic              aw_held, w_held, bvalid_q;
    logic [1:0]        bresp_q;
    logic [IDX_W-1:0]  idx;
    logic [31:0]       wdata_q;
    logic [31:0]       stage      [NUM_WORDS];
    logic [31:0]       stage_next [NUM_WORDS];
    logic [DATA_W-1:0] mem        [DEPTH];
    logic [DATA_W-1:0] push_data;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic is_word, is_ctrl, commit, flush, pop, stall, exec, push, flush_exec;
    logic unused_addr_lsb;

    // Byte lanes below the word boundary carry no meaning for this register map.
    assign unused_addr_lsb = ^bus.axi_awaddr[1:0];

    // Readies are held low during reset and while a transaction is in flight.
    assign bus.axi_awready = axi_aresetn && !aw_held && !bvalid_q;
    assign bus.axi_wready  = axi_aresetn && !w_held && !bvalid_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.tri_data    = mem[rd_ptr];
    assign bus.tri_valid   = (count != '0);
    assign bus.fifo_count  = count;
    assign bus.fifo_empty  = (count == '0);
    assign bus.fifo_full   = (count == FULL_CNT);

    // Decode the latched write and decide whether it may execute this cycle.
    // A flush frees the whole FIFO first, so a flush+commit never stalls.
    always_comb begin
        is_word    = (idx < CTRL_IDX);
        is_ctrl    = (idx == CTRL_IDX);
        flush      = is_ctrl && wdata_q[1];
        commit     = (is_ctrl && wdata_q[0]) || ((AUTO_COMMIT != 0) && (idx == LAST_IDX));
        pop        = bus.tri_ready && (count != '0);
        stall      = commit && !flush && (count == FULL_CNT) && !pop;
        exec       = aw_held && w_held && !bvalid_q && !stall;
        push       = exec && commit;
        flush_exec = exec && flush;
    end

    // Staging words with the executing write merged in; this is what a commit pushes.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            stage_next[i] = stage[i];
            if (exec && (idx == IDX_W'(i))) stage_next[i] = wdata_q;
            push_data[i*32 +: 32] = stage_next[i];
        end
    end

    // AW/W latches and the B response; one transaction outstanding at a time.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            idx      <= '0;
            wdata_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
        end else begin
            if (bus.axi_awvalid && bus.axi_awready) begin
                aw_held <= 1'b1;
                idx     <= bus.axi_awaddr[ADDR_W-1:2];
            end
            if (bus.axi_wvalid && bus.axi_wready) begin
                w_held  <= 1'b1;
                wdata_q <= bus.axi_wdata;
            end
            if (exec) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (is_word || is_ctrl) ? 2'b00 : 2'b10;
            end else if (bvalid_q && bus.axi_bready) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    // Staging register file.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int i = 0; i < NUM_WORDS; i++) stage[i] <= '0;
        end else begin
            stage <= stage_next;
        end
    end

    // FIFO pointers and occupancy; flush overrides a concurrent pop.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (flush_exec) begin
                rd_ptr <= wr_ptr;
                count  <= push ? CNT_W'(1) : '0;
            end else begin
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        end
    end

    // Descriptor storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge axi_aclk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule
